// File: rtl/mem_arb_pkg.sv
// Shared types and the 2-way round-robin pick used by both the write and the read
// channels of mem_if_arbiter.
package mem_arb_pkg;

    typedef logic req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rr_pick_t;

    // The favoured requester wins a tie; a lone requester wins regardless of prio.
    function automatic rr_pick_t rr_pick(input logic [1:0] req, input req_id_t prio);
        rr_pick_t pick;
        pick.valid = |req;
        pick.id    = prio;
        if (!req[prio] && req[~prio])
            pick.id = ~prio;
        return pick;
    endfunction

endpackage

// File: rtl/mem_arb_owner_fifo.sv
// Owner FIFO: remembers which requester issued each outstanding read so that
// in-order read data can be routed back to it.
module mem_arb_owner_fifo
    import mem_arb_pkg::*;
#(
    parameter  int RD_DEPTH = 4,
    localparam int PTR_W    = $clog2(RD_DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  req_id_t          push_id,
    input  logic             pop,
    output req_id_t          head_id,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    req_id_t          ids [RD_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(RD_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && (!full || pop);
    // A pop on an empty FIFO is only meaningful when it consumes the entry pushed this cycle.
    assign do_pop  = pop && (!empty || push);
    assign head_id = empty ? push_id : ids[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the id storage has no reset; the pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push)
            ids[wr_ptr] <= push_id;
    end

endmodule

// File: rtl/mem_if_arbiter.sv
// Two-requester arbiter for a single mem_if port: independent round-robin write and
// read channels, registered memory-side outputs, in-order read return via an owner FIFO.
module mem_if_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_ALEN = 2,
    parameter int DLEN     = 32,
    parameter int RD_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                r0_wen,
    input  logic [MEM_ALEN-1:0] r0_waddr,
    input  logic [DLEN-1:0]     r0_wdata,
    output logic                r0_wgnt,
    input  logic                r0_ren,
    input  logic [MEM_ALEN-1:0] r0_raddr,
    output logic                r0_rgnt,
    output logic [DLEN-1:0]     r0_rdata,
    output logic                r0_rvalid,
    input  logic                r1_wen,
    input  logic [MEM_ALEN-1:0] r1_waddr,
    input  logic [DLEN-1:0]     r1_wdata,
    output logic                r1_wgnt,
    input  logic                r1_ren,
    input  logic [MEM_ALEN-1:0] r1_raddr,
    output logic                r1_rgnt,
    output logic [DLEN-1:0]     r1_rdata,
    output logic                r1_rvalid,
    output logic                mem_wen,
    output logic [MEM_ALEN-1:0] mem_waddr,
    output logic [DLEN-1:0]     mem_wdata,
    output logic                mem_ren,
    output logic [MEM_ALEN-1:0] mem_raddr,
    input  logic [DLEN-1:0]     mem_rdata,
    input  logic                mem_rvalid,
    output logic                rd_orphan
);

    localparam int CNT_W = $clog2(RD_DEPTH) + 1;

    req_id_t          w_prio;
    req_id_t          r_prio;
    rr_pick_t         w_pick;
    rr_pick_t         r_pick;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    req_id_t          fifo_head;
    logic             rd_room;
    logic             rd_pop_ok;
    logic             orphan_evt;

    // A full FIFO still accepts a read when a return frees an entry in the same cycle.
    assign rd_room = !fifo_full || mem_rvalid;

    // NOTE: every always_comb output is assigned unconditionally, so no latch can be inferred.
    always_comb begin
        w_pick = rr_pick({r1_wen, r0_wen}, w_prio);
        r_pick = rr_pick({r1_ren, r0_ren} & {2{rd_room}}, r_prio);
    end

    assign r0_wgnt = w_pick.valid && (w_pick.id == REQ0);
    assign r1_wgnt = w_pick.valid && (w_pick.id == REQ1);
    assign r0_rgnt = r_pick.valid && (r_pick.id == REQ0);
    assign r1_rgnt = r_pick.valid && (r_pick.id == REQ1);

    assign rd_pop_ok  = mem_rvalid && (!fifo_empty || r_pick.valid);
    assign orphan_evt = mem_rvalid && (fifo_count == '0) && !r_pick.valid;

    mem_arb_owner_fifo #(
        .RD_DEPTH (RD_DEPTH)
    ) u_owner_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push    (r_pick.valid),
        .push_id (r_pick.id),
        .pop     (mem_rvalid),
        .head_id (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_prio    <= REQ0;
            r_prio    <= REQ0;
            mem_wen   <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            mem_ren   <= 1'b0;
            mem_raddr <= '0;
            r0_rvalid <= 1'b0;
            r0_rdata  <= '0;
            r1_rvalid <= 1'b0;
            r1_rdata  <= '0;
            rd_orphan <= 1'b0;
        end else begin
            mem_wen <= w_pick.valid;
            if (w_pick.valid) begin
                mem_waddr <= (w_pick.id == REQ1) ? r1_waddr : r0_waddr;
                mem_wdata <= (w_pick.id == REQ1) ? r1_wdata : r0_wdata;
                w_prio    <= req_id_t'(~w_pick.id);
            end

            mem_ren <= r_pick.valid;
            if (r_pick.valid) begin
                mem_raddr <= (r_pick.id == REQ1) ? r1_raddr : r0_raddr;
                r_prio    <= req_id_t'(~r_pick.id);
            end

            r0_rvalid <= rd_pop_ok && (fifo_head == REQ0);
            r1_rvalid <= rd_pop_ok && (fifo_head == REQ1);
            if (rd_pop_ok && (fifo_head == REQ0))
                r0_rdata <= mem_rdata;
            if (rd_pop_ok && (fifo_head == REQ1))
                r1_rdata <= mem_rdata;

            if (orphan_evt)
                rd_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_if_arbiter.sv
// Directed bench for mem_if_arbiter: a per-cycle vector table plus hand-written
// sequences for FIFO-full back-pressure and reset with reads outstanding.
module tb_mem_if_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        r0_wen, r1_wen, r0_ren, r1_ren;
    logic [1:0]  r0_waddr, r1_waddr, r0_raddr, r1_raddr;
    logic [31:0] r0_wdata, r1_wdata;
    logic        r0_wgnt, r1_wgnt, r0_rgnt, r1_rgnt;
    logic [31:0] r0_rdata, r1_rdata;
    logic        r0_rvalid, r1_rvalid;
    logic        mem_wen, mem_ren;
    logic [1:0]  mem_waddr, mem_raddr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_rvalid;
    logic        rd_orphan;

    int n_checks = 0;
    int n_errors = 0;

    mem_if_arbiter #(.MEM_ALEN(2), .DLEN(32), .RD_DEPTH(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .r0_wen     (r0_wen),
        .r0_waddr   (r0_waddr),
        .r0_wdata   (r0_wdata),
        .r0_wgnt    (r0_wgnt),
        .r0_ren     (r0_ren),
        .r0_raddr   (r0_raddr),
        .r0_rgnt    (r0_rgnt),
        .r0_rdata   (r0_rdata),
        .r0_rvalid  (r0_rvalid),
        .r1_wen     (r1_wen),
        .r1_waddr   (r1_waddr),
        .r1_wdata   (r1_wdata),
        .r1_wgnt    (r1_wgnt),
        .r1_ren     (r1_ren),
        .r1_raddr   (r1_raddr),
        .r1_rgnt    (r1_rgnt),
        .r1_rdata   (r1_rdata),
        .r1_rvalid  (r1_rvalid),
        .mem_wen    (mem_wen),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_ren    (mem_ren),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .rd_orphan  (rd_orphan)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // One record per cycle: inputs, the same-cycle grants {r1_rgnt,r0_rgnt,r1_wgnt,r0_wgnt},
    // and the registered outputs expected right after the following clock edge.
    typedef struct {
        logic [1:0]  wen;
        logic [1:0]  wa0, wa1;
        logic [1:0]  ren;
        logic [1:0]  ra0, ra1;
        logic        mrv;
        logic [31:0] mrd;
        logic [3:0]  gnt;
        logic        mwen;
        logic [1:0]  mwa;
        logic [31:0] mwd;
        logic        mren;
        logic [1:0]  mra;
        logic [1:0]  rv;
        logic [31:0] rd;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_rd0, exp_rd1;

    task automatic idle_inputs();
        r0_wen = 0; r1_wen = 0; r0_ren = 0; r1_ren = 0;
        r0_waddr = 0; r1_waddr = 0; r0_raddr = 0; r1_raddr = 0;
        r0_wdata = 0; r1_wdata = 0;
        mem_rvalid = 0; mem_rdata = 0;
    endtask

    task automatic check_all_reset(input string tag);
        check({tag, "_mem_wen"}, mem_wen, 0);
        check({tag, "_mem_waddr"}, mem_waddr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_mem_ren"}, mem_ren, 0);
        check({tag, "_mem_raddr"}, mem_raddr, 0);
        check({tag, "_rvalid"}, {r1_rvalid, r0_rvalid}, 0);
        check({tag, "_r0_rdata"}, r0_rdata, 0);
        check({tag, "_r1_rdata"}, r1_rdata, 0);
    endtask

    initial begin
        // Write channel: round-robin from reset, then lone requests regardless of pointer.
        vecs.push_back('{2'b11, 2'd0, 2'd2, 2'b00, 2'd0, 2'd0, 1'b0, 32'h0, 4'b0001, 1'b1, 2'd0, 32'hA5A5_0000, 1'b0, 2'd0, 2'b00, 32'h0});
        vecs.push_back('{2'b11, 2'd0, 2'd2, 2'b00, 2'd0, 2'd0, 1'b0, 32'h0, 4'b0010, 1'b1, 2'd2, 32'hB6B6_0002, 1'b0, 2'd0, 2'b00, 32'h0});
        vecs.push_back('{2'b11, 2'd0, 2'd2, 2'b00, 2'd0, 2'd0, 1'b0, 32'h0, 4'b0001, 1'b1, 2'd0, 32'hA5A5_0000, 1'b0, 2'd0, 2'b00, 32'h0});
        vecs.push_back('{2'b11, 2'd0, 2'd2, 2'b00, 2'd0, 2'd0, 1'b0, 32'h0, 4'b0010, 1'b1, 2'd2, 32'hB6B6_0002, 1'b0, 2'd0, 2'b00, 32'h0});
        vecs.push_back('{2'b01, 2'd1, 2'd0, 2'b00, 2'd0, 2'd0, 1'b0, 32'h0, 4'b0001, 1'b1, 2'd1, 32'hA5A5_0001, 1'b0, 2'd0, 2'b00, 32'h0});
        vecs.push_back('{2'b01, 2'd3, 2'd0, 2'b00, 2'd0, 2'd0, 1'b0, 32'h0, 4'b0001, 1'b1, 2'd3, 32'hA5A5_0003, 1'b0, 2'd0, 2'b00, 32'h0});
        vecs.push_back('{2'b00, 2'd0, 2'd0, 2'b00, 2'd0, 2'd0, 1'b0, 32'h0, 4'b0000, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 2'b00, 32'h0});
        // Reads: r0 addr 2, r1 addr 3, data returns three cycles after each mem_ren.
        vecs.push_back('{2'b00, 2'd0, 2'd0, 2'b01, 2'd2, 2'd0, 1'b0, 32'h0, 4'b0100, 1'b0, 2'd0, 32'h0, 1'b1, 2'd2, 2'b00, 32'h0});
        vecs.push_back('{2'b00, 2'd0, 2'd0, 2'b10, 2'd0, 2'd3, 1'b0, 32'h0, 4'b1000, 1'b0, 2'd0, 32'h0, 1'b1, 2'd3, 2'b00, 32'h0});
        vecs.push_back('{2'b00, 2'd0, 2'd0, 2'b00, 2'd0, 2'd0, 1'b0, 32'h0, 4'b0000, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 2'b00, 32'h0});
        vecs.push_back('{2'b00, 2'd0, 2'd0, 2'b00, 2'd0, 2'd0, 1'b0, 32'h0, 4'b0000, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 2'b00, 32'h0});
        vecs.push_back('{2'b00, 2'd0, 2'd0, 2'b00, 2'd0, 2'd0, 1'b1, 32'hD000_0002, 4'b0000, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 2'b01, 32'hD000_0002});
        vecs.push_back('{2'b00, 2'd0, 2'd0, 2'b00, 2'd0, 2'd0, 1'b1, 32'hD000_0003, 4'b0000, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 2'b10, 32'hD000_0003});
        vecs.push_back('{2'b00, 2'd0, 2'd0, 2'b00, 2'd0, 2'd0, 1'b0, 32'h0, 4'b0000, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 2'b00, 32'h0});
        // Simultaneous write (r0) and read (r1) grants, then overlapping grants and returns.
        vecs.push_back('{2'b01, 2'd2, 2'd0, 2'b10, 2'd0, 2'd1, 1'b0, 32'h0, 4'b1001, 1'b1, 2'd2, 32'hA5A5_0002, 1'b1, 2'd1, 2'b00, 32'h0});
        vecs.push_back('{2'b00, 2'd0, 2'd0, 2'b11, 2'd0, 2'd2, 1'b1, 32'hD000_0001, 4'b0100, 1'b0, 2'd0, 32'h0, 1'b1, 2'd0, 2'b10, 32'hD000_0001});
        vecs.push_back('{2'b11, 2'd3, 2'd1, 2'b00, 2'd0, 2'd0, 1'b1, 32'hD000_0000, 4'b0010, 1'b1, 2'd1, 32'hB6B6_0001, 1'b0, 2'd0, 2'b01, 32'hD000_0000});
        vecs.push_back('{2'b00, 2'd0, 2'd0, 2'b00, 2'd0, 2'd0, 1'b0, 32'h0, 4'b0000, 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 2'b00, 32'h0});

        idle_inputs();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_reset("reset");
        check("reset_orphan", rd_orphan, 0);
        @(negedge clk);
        rstn = 1'b1;

        exp_rd0 = 32'h0;
        exp_rd1 = 32'h0;
        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            @(negedge clk);
            r0_wen = v.wen[0]; r1_wen = v.wen[1];
            r0_waddr = v.wa0; r1_waddr = v.wa1;
            r0_wdata = 32'hA5A5_0000 | 32'(v.wa0);
            r1_wdata = 32'hB6B6_0000 | 32'(v.wa1);
            r0_ren = v.ren[0]; r1_ren = v.ren[1];
            r0_raddr = v.ra0; r1_raddr = v.ra1;
            mem_rvalid = v.mrv; mem_rdata = v.mrd;
            #1;
            check($sformatf("v%0d_gnt", i), {r1_rgnt, r0_rgnt, r1_wgnt, r0_wgnt}, v.gnt);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_mem_wen", i), mem_wen, v.mwen);
            if (v.mwen) begin
                check($sformatf("v%0d_mem_waddr", i), mem_waddr, v.mwa);
                check($sformatf("v%0d_mem_wdata", i), mem_wdata, v.mwd);
            end
            check($sformatf("v%0d_mem_ren", i), mem_ren, v.mren);
            if (v.mren)
                check($sformatf("v%0d_mem_raddr", i), mem_raddr, v.mra);
            check($sformatf("v%0d_rvalid", i), {r1_rvalid, r0_rvalid}, v.rv);
            if (v.rv[0]) exp_rd0 = v.rd;
            if (v.rv[1]) exp_rd1 = v.rd;
            check($sformatf("v%0d_r0_rdata", i), r0_rdata, exp_rd0);
            check($sformatf("v%0d_r1_rdata", i), r1_rdata, exp_rd1);
            check($sformatf("v%0d_orphan", i), rd_orphan, 0);
        end
        idle_inputs();

        // FIFO full: four r1 reads granted, the fifth waits until a return frees an entry.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            r1_ren = 1'b1;
            r1_raddr = 2'(i);
            #1;
            check($sformatf("full_gnt%0d", i), r1_rgnt, 1);
        end
        @(negedge clk);
        r1_raddr = 2'd0;
        #1;
        check("full_block0", r1_rgnt, 0);
        check("full_last_mem_ren", mem_ren, 1);
        check("full_last_mem_raddr", mem_raddr, 3);
        @(negedge clk);
        #1;
        check("full_block1", r1_rgnt, 0);
        check("full_idle_mem_ren", mem_ren, 0);
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata = 32'hD000_0010;
        #1;
        check("full_pop_gnt", r1_rgnt, 1);
        @(negedge clk);
        r1_ren = 1'b0;
        mem_rvalid = 1'b0;
        #1;
        check("full_pop_rvalid", {r1_rvalid, r0_rvalid}, 2'b10);
        check("full_pop_rdata", r1_rdata, 32'hD000_0010);
        check("full_fifth_mem_ren", mem_ren, 1);
        check("full_fifth_mem_raddr", mem_raddr, 0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            mem_rvalid = 1'b1;
            mem_rdata = 32'hD000_0010 + 32'(i);
            @(posedge clk);
            #1;
            check($sformatf("drain%0d_rvalid", i), {r1_rvalid, r0_rvalid}, 2'b10);
            check($sformatf("drain%0d_rdata", i), r1_rdata, 32'hD000_0010 + 32'(i));
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        check("drain_orphan", rd_orphan, 0);

        // Reset with two reads outstanding; the stale return afterwards is an orphan.
        @(negedge clk);
        r0_ren = 1'b1;
        r0_raddr = 2'd1;
        #1;
        check("rst_rd0_gnt", r0_rgnt, 1);
        @(negedge clk);
        r0_raddr = 2'd2;
        r1_wen = 1'b1;
        r1_waddr = 2'd3;
        r1_wdata = 32'hB6B6_0003;
        #1;
        check("rst_rd1_gnt", r0_rgnt, 1);
        @(negedge clk);
        idle_inputs();
        #2;
        rstn = 1'b0;
        #1;
        check_all_reset("midrst");
        check("midrst_orphan", rd_orphan, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata = 32'hDEAD_0001;
        #1;
        check("stale_no_gnt", {r1_rgnt, r0_rgnt, r1_wgnt, r0_wgnt}, 0);
        @(posedge clk);
        #1;
        check_all_reset("stale");
        check("stale_orphan", rd_orphan, 1);
        @(negedge clk);
        mem_rvalid = 1'b0;
        r0_ren = 1'b1;
        r0_raddr = 2'd3;
        r1_ren = 1'b1;
        #1;
        check("post_rst_prio", {r1_rgnt, r0_rgnt}, 2'b01);
        @(posedge clk);
        #1;
        check("orphan_sticky", rd_orphan, 1);
        check("post_rst_mem_raddr", mem_raddr, 3);
        @(negedge clk);
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
